// File: rtl/btn_bounce_gen.sv
`timescale 1ns/1ps
// btn_bounce_gen: push-button emulator. Each accepted press/release drives the
// registered button line through an LFSR-shaped burst of contact bounce, then holds the settled level.
module btn_bounce_gen #(
  parameter int          SETTLE_CYC  = 1_000_000,
  parameter int          BOUNCE_BITS = 3,
  parameter int          GLITCH_BITS = 3,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                                               i_clk,
  input  logic                                               i_reset,
  input  logic                                               i_press_req,
  input  logic                                               i_release_req,
  output logic                                               o_btn,
  output logic                                               o_level,
  output logic                                               o_busy,
  output logic                                               o_done,
  output logic [((BOUNCE_BITS > 0) ? BOUNCE_BITS : 1)-1:0]   o_glitches
);

  localparam int GLW  = (BOUNCE_BITS > 0) ? BOUNCE_BITS : 1;
  localparam int SETW = $clog2(SETTLE_CYC + 1);
  localparam int WIDW = GLITCH_BITS + 1;
  localparam int SEGW = BOUNCE_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            btn_q, btn_d;
  logic            level_q, level_d;
  logic            done_q, done_d;
  logic            target_q, target_d;
  logic [GLW-1:0]  glitches_q, glitches_d;
  logic [SEGW-1:0] seg_q, seg_d;
  logic [WIDW-1:0] wid_q, wid_d;
  logic [SETW-1:0] settle_q, settle_d;

  logic            press_ok, release_ok, accept;
  logic [GLW-1:0]  k;
  logic [SEGW-1:0] seg_load;
  logic [WIDW-1:0] width_load;
  logic            seg_last, wid_last, settle_last;

  if (BOUNCE_BITS > 0) begin : g_k
    assign k = lfsr_q[BOUNCE_BITS-1:0];
  end else begin : g_k_clean
    assign k = '0;
  end

  // Only the request that moves the line away from its settled level can qualify.
  assign press_ok    = i_press_req && !level_q;
  assign release_ok  = i_release_req && level_q;
  assign accept      = (state_q == S_IDLE) && (press_ok || release_ok);
  assign seg_load    = SEGW'({k, 1'b0});
  assign width_load  = WIDW'(lfsr_q[8 +: GLITCH_BITS]) + WIDW'(1);
  assign seg_last    = (seg_q == SEGW'(1));
  assign wid_last    = (wid_q == WIDW'(1));
  assign settle_last = (settle_q == SETW'(1));
  assign lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      btn_q      <= 1'b0;
      level_q    <= 1'b0;
      done_q     <= 1'b0;
      target_q   <= 1'b0;
      glitches_q <= '0;
      seg_q      <= '0;
      wid_q      <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      btn_q      <= btn_d;
      level_q    <= level_d;
      done_q     <= done_d;
      target_q   <= target_d;
      glitches_q <= glitches_d;
      seg_q      <= seg_d;
      wid_q      <= wid_d;
      settle_q   <= settle_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = (k == '0) ? S_HOLD : S_BOUNCE;
      S_BOUNCE: if (wid_last && seg_last) state_d = S_HOLD;
      S_HOLD:   if (settle_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    btn_d      = btn_q;
    level_d    = level_q;
    done_d     = 1'b0;
    target_d   = target_q;
    glitches_d = glitches_q;
    seg_d      = seg_q;
    wid_d      = wid_q;
    settle_d   = settle_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          target_d   = press_ok;
          btn_d      = press_ok;
          glitches_d = k;
          seg_d      = seg_load;
          wid_d      = width_load;
          settle_d   = SETW'(SETTLE_CYC);
        end
      end
      S_BOUNCE: begin
        if (wid_last) begin
          seg_d = seg_q - SEGW'(1);
          if (seg_last) begin
            btn_d    = target_q;
            settle_d = SETW'(SETTLE_CYC);
          end else begin
            btn_d = ~btn_q;
            wid_d = width_load;
          end
        end else begin
          wid_d = wid_q - WIDW'(1);
        end
      end
      S_HOLD: begin
        if (settle_last) begin
          done_d  = 1'b1;
          level_d = target_q;
        end else begin
          settle_d = settle_q - SETW'(1);
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign o_btn      = btn_q;
  assign o_level    = level_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = done_q;
  assign o_glitches = glitches_q;

endmodule

// File: tb/tb_btn_bounce_gen.sv
`timescale 1ns/1ps
// Bench for btn_bounce_gen: reset checks, clean-edge vector table, LFSR-predicted
// bounce transitions, and a closed loop through a debounce/toggle model.
module tb_btn_bounce_gen;

  localparam int          SETTLE = 100;
  localparam int          DEB    = 20;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       press, rel, btn, level, busy, done;
  logic [2:0] glitches;
  logic       press0, rel0, btn0, level0, busy0, done0, glitches0;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic cur_level;
  int   r0, f0;

  always #5 clk = ~clk;

  btn_bounce_gen #(.SETTLE_CYC(SETTLE), .BOUNCE_BITS(3), .GLITCH_BITS(3), .SEED(SEED)) dut (
    .i_clk(clk), .i_reset(rst), .i_press_req(press), .i_release_req(rel),
    .o_btn(btn), .o_level(level), .o_busy(busy), .o_done(done), .o_glitches(glitches)
  );

  btn_bounce_gen #(.SETTLE_CYC(SETTLE), .BOUNCE_BITS(0), .GLITCH_BITS(3), .SEED(SEED)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_press_req(press0), .i_release_req(rel0),
    .o_btn(btn0), .o_level(level0), .o_busy(busy0), .o_done(done0), .o_glitches(glitches0)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  // Debounce/toggle consumer: a level must hold DEB cycles before it is believed.
  logic deb_q, led;
  int   deb_cnt, rises, falls;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= 1'b0; led <= 1'b0; deb_cnt <= 0; rises <= 0; falls <= 0;
    end else if (btn == deb_q) begin
      deb_cnt <= 0;
    end else if (deb_cnt == DEB - 1) begin
      deb_q   <= btn;
      deb_cnt <= 0;
      if (btn) begin
        rises <= rises + 1;
        led   <= ~led;
      end else begin
        falls <= falls + 1;
      end
    end else begin
      deb_cnt <= deb_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Predicts the whole o_btn waveform from the bench LFSR, then compares cycle by cycle.
  task automatic do_transition(input logic tgt, input bit noise);
    logic [15:0] l;
    int          k, w, mism, busy_bad, edges;
    logic        exp_q[$];
    logic        prev;
    l = m_lfsr;
    k = int'(l[2:0]);
    for (int j = 0; j < 2 * k; j++) begin
      w = int'(l[10:8]) + 1;
      for (int c = 0; c < w; c++) exp_q.push_back((j % 2 == 0) ? tgt : ~tgt);
      for (int c = 0; c < w; c++) l = lfsr_step(l);
    end
    for (int c = 0; c < SETTLE; c++) exp_q.push_back(tgt);
    prev  = btn;
    press = tgt;
    rel   = ~tgt;
    if (noise && ($urandom_range(0, 3) == 0)) begin
      press = 1'b1;
      rel   = 1'b1;
    end
    mism = 0; busy_bad = 0; edges = 0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      press = noise && ($urandom_range(0, 9) == 0);
      rel   = noise && ($urandom_range(0, 9) == 0);
      if (btn !== exp_q[i]) mism++;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      if (btn !== prev) edges++;
      prev = btn;
    end
    @(negedge clk);
    press = 1'b0;
    rel   = 1'b0;
    check("btn_seq", mism, 0);
    check("busy_span", busy_bad, 0);
    check("edges", edges, 2 * k + 1);
    check("completion", {done, busy, level, btn}, {1'b1, 1'b0, tgt, tgt});
    check("glitches", glitches, k);
    cur_level = tgt;
  endtask

  typedef struct {
    logic       press;
    logic       rel;
    int         wait_cyc;
    logic [3:0] exp;      // {btn, busy, done, level}
    string      name;
  } vec_t;
  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1,   4'b0000, "clean_idle"};
    vecs[1]  = '{1'b0, 1'b1, 1,   4'b0000, "clean_release_ignored"};
    vecs[2]  = '{1'b1, 1'b0, 1,   4'b1100, "clean_press_t1"};
    vecs[3]  = '{1'b0, 1'b0, 99,  4'b1100, "clean_press_t100"};
    vecs[4]  = '{1'b0, 1'b0, 1,   4'b1011, "clean_press_done"};
    vecs[5]  = '{1'b0, 1'b0, 1,   4'b1001, "clean_press_after"};
    vecs[6]  = '{1'b1, 1'b0, 1,   4'b1001, "clean_press_ignored"};
    vecs[7]  = '{1'b0, 1'b1, 1,   4'b0101, "clean_release_t1"};
    vecs[8]  = '{1'b1, 1'b1, 50,  4'b0101, "clean_reqs_while_busy"};
    vecs[9]  = '{1'b0, 1'b0, 49,  4'b0101, "clean_release_t100"};
    vecs[10] = '{1'b0, 1'b0, 1,   4'b0010, "clean_release_done"};
    vecs[11] = '{1'b1, 1'b1, 1,   4'b1100, "clean_both_back_to_back"};
    vecs[12] = '{1'b0, 1'b0, 100, 4'b1011, "clean_b2b_done"};

    press = 1'b0; rel = 1'b0; press0 = 1'b0; rel0 = 1'b0; cur_level = 1'b0;

    #1;
    check("reset_outputs", {btn, level, busy, done, glitches}, 7'b0);
    repeat (3) @(negedge clk);

    // First press lands on the first edge after reset, so k comes straight from SEED.
    rst   = 1'b0;
    press = 1'b1;
    @(negedge clk);
    press = 1'b0;
    check("first_k_from_seed", glitches, 3'd1);
    check("first_accept", {btn, busy, done, level}, 4'b1100);

    // Asynchronous reset in the middle of the first bounce segment.
    #2 rst = 1'b1;
    #1 check("async_reset_mid_bounce", {btn, level, busy, done, glitches}, 7'b0);
    @(negedge clk);
    rst = 1'b0;
    do_transition(1'b1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        press = cur_level;
        rel   = ~cur_level;
        repeat (gap) begin
          @(negedge clk);
          press = 1'b0;
          rel   = 1'b0;
        end
        check("same_level_ignored", {busy, btn, level}, {1'b0, cur_level, cur_level});
      end
      do_transition(~cur_level, 1'b1);
    end

    if (cur_level) do_transition(1'b0, 1'b0);
    r0 = rises;
    f0 = falls;
    for (int n = 0; n < 4; n++) begin
      do_transition(1'b1, 1'b1);
      do_transition(1'b0, 1'b1);
    end
    check("loop_led_toggles", rises - r0, 4);
    check("loop_releases", falls - f0, 4);

    for (int i = 0; i < 13; i++) begin
      press0 = vecs[i].press;
      rel0   = vecs[i].rel;
      repeat (vecs[i].wait_cyc) begin
        @(negedge clk);
        press0 = 1'b0;
        rel0   = 1'b0;
      end
      check(vecs[i].name, {btn0, busy0, done0, level0}, vecs[i].exp);
    end
    check("clean_glitches", glitches0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish in time");
  end

endmodule

// File: doc/btn_bounce_gen.md
# btn_bounce_gen

Synthesizable mechanical-push-button emulator: on a press or release request it drives a single-bit button line with a pseudo-random burst of contact-bounce glitches, then holds the settled level for a programmable time. It sits on the stimulus side of our button-input path and drives the button input of the debounce/toggle logic for on-board self-test and closed-loop simulation, so the same stimulus can be used in silicon and in benches.

## Interface
- SETTLE_CYC, 1_000_000: cycles the settled level is held after bouncing (10 ms at 100 MHz); must be ≥1.
- BOUNCE_BITS, 3: glitch count per transition is 0..2^BOUNCE_BITS−1; 0 means clean edges with no glitches.
- GLITCH_BITS, 3: each bounce segment is 1..2^GLITCH_BITS cycles wide.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- i_clk  in  1  system clock, 100 MHz
- i_reset  in  1  asynchronous, active-high reset
- i_press_req  in  1  single-cycle request to transition the line to 1
- i_release_req  in  1  single-cycle request to transition the line to 0
- o_btn  out  1  emulated raw button line, registered
- o_level  out  1  last settled logical level
- o_busy  out  1  high while a transition is in progress
- o_done  out  1  one-cycle pulse when a transition completes
- o_glitches  out  max(BOUNCE_BITS,1)  glitch count of the current or last transition

## Operation
- LFSR: 16-bit Galois, taps 16'hB400, shifts every cycle from reset. It is never stalled.
- States: IDLE, BOUNCE, HOLD.
- IDLE:
  - A request is accepted only if o_busy=0 and the requested level ≠ o_level. The target T is that requested level.
  - Any other request is ignored and has no side effect.
  - If both requests are asserted together, only the one opposite to o_level can qualify, so it is accepted.
- On acceptance:
  - k = lfsr[BOUNCE_BITS−1:0], or 0 if BOUNCE_BITS=0.
  - o_glitches ← k.
  - The bounce-segment counter is loaded with 2k.
  - Next state is BOUNCE, or HOLD if k=0.
- BOUNCE:
  - Emits 2k segments that alternate T, ~T, T, ~T, …; segment 1 is at T.
  - Each segment width w = lfsr[8+GLITCH_BITS−1:8] + 1, sampled on the cycle the segment starts.
  - After the last (~T) segment, go to HOLD.
- HOLD: o_btn = T for exactly SETTLE_CYC cycles, then go to IDLE.
- Completion: on entering IDLE, o_done = 1 for one cycle, o_level ← T and o_busy ← 0, all in the same cycle.
- o_level changes only at completion. o_btn never changes in IDLE.
- o_glitches holds its value until the next accepted request.
- Counter widths:
  - Settle counter: $clog2(SETTLE_CYC+1) bits.
  - Segment-width counter: GLITCH_BITS+1 bits.
  - Segment counter: BOUNCE_BITS+1 bits.
  - No counter wraps.

## Timing
- Reset values: o_btn=0, o_level=0, o_busy=0, o_done=0, o_glitches=0, lfsr=SEED, state IDLE. Reset takes effect immediately, including mid-transition; any in-flight transition is discarded.
- Request sampled high at edge t:
  - o_busy=1 and o_btn=T in cycle t+1.
- Transition duration:
  - Total o_busy-high cycles = Σw (over 2k segments) + SETTLE_CYC.
  - o_done is asserted in the first cycle after that span.
  - For k=0: o_btn = T from t+1 through t+SETTLE_CYC, and o_done is in cycle t+SETTLE_CYC+1.
- Back-to-back: a new request is accepted in the o_done cycle, since o_busy is already 0 there.
- Requests arriving while o_busy=1 are dropped, not queued.
- o_btn is glitch-free at the cycle level; it is driven directly from a flop.

## Test plan
- Reset behaviour: assert i_reset mid-BOUNCE -> all outputs 0 asynchronously. After release, a press is accepted and the first k equals SEED's low BOUNCE_BITS bits (k=1 for 16'hACE1 with BOUNCE_BITS=3).
- Clean edge (BOUNCE_BITS=0, SETTLE_CYC=100): press at edge t:
  - o_btn rises at t+1.
  - o_busy is high for 100 cycles.
  - o_done pulses at t+101 with o_level=1.
  - Release mirrors this with o_btn falling at t+1.
- Bounce shape (BOUNCE_BITS=3, GLITCH_BITS=3, SETTLE_CYC=100), 200 random press/release cycles:
  - o_btn shows exactly 2·o_glitches edges before the final settled edge.
  - Every pre-settle segment is 1–8 cycles wide.
  - The final stable run is ≥100 cycles.
  - Scoreboard the full sequence against a bench LFSR model.
- Ignored requests:
  - Press while o_level=1 -> no o_busy, o_btn unchanged.
  - Press/release pulses during o_busy -> no change in duration or sequence.
  - Both requests together with o_level=0 -> press is accepted.
- Back-to-back: release issued in the o_done cycle of a press -> accepted, o_busy stays 0 for exactly one cycle.
- Closed loop: connect o_btn to the debounce/toggle block with the debounce time < SETTLE_CYC; run 4 press/release pairs -> the LED toggles exactly 4 times, once per press, and never on a glitch.
